// File: rtl/camera_pkg.sv
// Shared constants and FSM encoding for the OV7670 SCCB register loader.
package camera_pkg;

    localparam logic [7:0]  OV7670_WR_ID = 8'h42;
    localparam logic [15:0] TABLE_END    = 16'hFFFF;
    localparam logic [7:0]  DELAY_TAG    = 8'hF0;
    localparam int          CLK_PER_MS   = 25000;

    typedef enum logic [3:0] {
        ST_IDLE   = 4'd0,
        ST_FETCH  = 4'd1,
        ST_DECODE = 4'd2,
        ST_START  = 4'd3,
        ST_BYTE   = 4'd4,
        ST_STOP   = 4'd5,
        ST_GAP    = 4'd6,
        ST_DELAY  = 4'd7,
        ST_DONE   = 4'd8
    } sccb_state_e;

endpackage

// File: rtl/sccb_rom.sv
// Register table for the OV7670 loader: {reg, value} per entry, 1-clk registered read.
// TABLE_SEL 0 is the power-up list; the other selections are short bring-up tables.
// An entry {DELAY_TAG, n} requests an n ms pause when SCCB_DELAY_EN is defined.
module sccb_rom
    import camera_pkg::*;
#(
    parameter int TABLE_SEL = 0
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [7:0]  addr,
    output logic [15:0] data
);

    logic [15:0] data_d;
    logic [15:0] data_q;

    // Table lookup; every unlisted address reads as the terminator.
    always_comb begin
        data_d = TABLE_END;
        case (TABLE_SEL)
            1: case (addr)
                   8'd0:    data_d = 16'h1280;
                   default: data_d = TABLE_END;
               endcase
            2: case (addr)
                   8'd0:    data_d = 16'h3A04;
                   8'd1:    data_d = 16'h40D0;
                   default: data_d = TABLE_END;
               endcase
            3: data_d = TABLE_END;
            4: case (addr)
                   8'd0:    data_d = 16'h1280;
                   8'd1:    data_d = 16'hF002;
                   8'd2:    data_d = 16'h1101;
                   default: data_d = TABLE_END;
               endcase
            default: case (addr)
                   8'd0:    data_d = 16'h1280;  // COM7 soft reset
                   8'd1:    data_d = 16'hF00A;  // settle after soft reset
                   8'd2:    data_d = 16'h1214;  // COM7: QVGA, RGB
                   8'd3:    data_d = 16'h1101;  // CLKRC prescaler
                   8'd4:    data_d = 16'h0C04;  // COM3: scaling enable
                   8'd5:    data_d = 16'h3E19;  // COM14: PCLK divider
                   8'd6:    data_d = 16'h40D0;  // COM15: RGB565 full range
                   8'd7:    data_d = 16'h8C00;  // RGB444 off
                   8'd8:    data_d = 16'h3A04;  // TSLB
                   default: data_d = TABLE_END;
               endcase
        endcase
    end

    // Registered read port.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) data_q <= TABLE_END;
        else          data_q <= data_d;
    end

    assign data = data_q;

endmodule

// File: rtl/sccb_config.sv
// OV7670 power-up loader: walks sccb_rom and issues one 3-phase SCCB write per entry.
// Build option: SCCB_DELAY_EN turns {F0,n} entries into n ms bus-idle pauses.
//
//   state  | meaning
//   IDLE   | waiting for start, bus idle
//   FETCH  | table read in flight for reg_idx
//   DECODE | terminator / index limit / delay tag / normal write
//   START  | sioc high, siod falls at mid-bit
//   BYTE   | 8 data bits MSB first + released 9th bit, 3 bytes
//   STOP   | siod low, sioc rises, siod rises at mid-bit
//   GAP    | GAP_BITS idle bit-times before next entry
//   DELAY  | ms pause with bus idle (SCCB_DELAY_EN only)
//   DONE   | table finished, done held until next start
module sccb_config
    import camera_pkg::*;
#(
    parameter int         QTR_CYC   = 63,
    parameter logic [7:0] DEV_ID    = OV7670_WR_ID,
    parameter int         NUM_REGS  = 64,
    parameter int         GAP_BITS  = 4,
    parameter int         TABLE_SEL = 0
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       start,
    output logic       busy,
    output logic       done,
    output logic [7:0] reg_idx,
    output logic       sioc,
    output logic       siod_o,
    output logic       siod_oe
);

    localparam int          QW          = (QTR_CYC > 1) ? $clog2(QTR_CYC) : 1;
    localparam logic [QW-1:0] QTR_CYC_M1 = QW'(QTR_CYC - 1);

    sccb_state_e   state_q, state_d;
    logic [QW-1:0] qcnt_q, qcnt_d;
    logic [1:0]    phase_q, phase_d;
    logic [3:0]    bit_q, bit_d;
    logic [1:0]    byte_q, byte_d;
    logic [7:0]    idx_q, idx_d;
    logic [15:0]   rom_data;
    logic [7:0]    cur_byte;
    logic          busy_w, qt, bit_end;
`ifdef SCCB_DELAY_EN
    logic [22:0]   ms_q, ms_d;
`endif

    sccb_rom #(.TABLE_SEL(TABLE_SEL)) u_rom (
        .clk     (clk),
        .reset_n (reset_n),
        .addr    (idx_q),
        .data    (rom_data)
    );

    assign busy_w  = (state_q != ST_IDLE) && (state_q != ST_DONE);
    assign qt      = busy_w && (qcnt_q == '0);
    assign bit_end = qt && (phase_q == 2'd3);
    assign busy    = busy_w;
    assign done    = (state_q == ST_DONE);
    assign reg_idx = idx_q;

    // Quarter-bit timer: reload-on-zero down-counter, parked at 0 when not busy.
    always_comb begin
        qcnt_d = '0;
        if (busy_w) qcnt_d = (qcnt_q == '0) ? QTR_CYC_M1 : qcnt_q - QW'(1);
    end

    // Byte currently on the wire.
    always_comb begin
        case (byte_q)
            2'd0:    cur_byte = DEV_ID;
            2'd1:    cur_byte = rom_data[15:8];
            default: cur_byte = rom_data[7:0];
        endcase
    end

    // Next-state and bus drive; phase advances on every quarter tick inside a bit.
    always_comb begin
        state_d = state_q;
        phase_d = qt ? phase_q + 2'd1 : phase_q;
        bit_d   = bit_q;
        byte_d  = byte_q;
        idx_d   = idx_q;
        sioc    = 1'b1;
        siod_o  = 1'b1;
        siod_oe = 1'b0;
`ifdef SCCB_DELAY_EN
        ms_d    = ms_q;
`endif
        case (state_q)
            ST_IDLE, ST_DONE: begin
                phase_d = 2'd0;
                if (start) begin
                    idx_d   = 8'd0;
                    state_d = ST_FETCH;
                end
            end
            ST_FETCH: begin
                phase_d = 2'd0;
                state_d = ST_DECODE;
            end
            ST_DECODE: begin
                phase_d = 2'd0;
                bit_d   = 4'd0;
                byte_d  = 2'd0;
                if (idx_q == 8'(NUM_REGS) || rom_data == TABLE_END) begin
                    state_d = ST_DONE;
`ifdef SCCB_DELAY_EN
                end else if (rom_data[15:8] == DELAY_TAG) begin
                    ms_d    = 23'(rom_data[7:0]) * 23'(CLK_PER_MS);
                    state_d = ST_DELAY;
`endif
                end else begin
                    state_d = ST_START;
                end
            end
            ST_START: begin
                siod_oe = 1'b1;
                siod_o  = (phase_q < 2'd2);
                if (bit_end) state_d = ST_BYTE;
            end
            ST_BYTE: begin
                sioc    = phase_q[1];
                siod_oe = (bit_q != 4'd8);
                siod_o  = (bit_q == 4'd8) ? 1'b1 : cur_byte[3'(4'd7 - bit_q)];
                if (bit_end) begin
                    if (bit_q == 4'd8) begin
                        bit_d = 4'd0;
                        if (byte_q == 2'd2) state_d = ST_STOP;
                        else                byte_d  = byte_q + 2'd1;
                    end else begin
                        bit_d = bit_q + 4'd1;
                    end
                end
            end
            ST_STOP: begin
                siod_oe = 1'b1;
                sioc    = (phase_q != 2'd0);
                siod_o  = phase_q[1];
                if (bit_end) begin
                    bit_d   = 4'd0;
                    state_d = ST_GAP;
                end
            end
            ST_GAP: begin
                if (bit_end) begin
                    if (bit_q == 4'(GAP_BITS - 1)) begin
                        bit_d   = 4'd0;
                        idx_d   = idx_q + 8'd1;
                        state_d = ST_FETCH;
                    end else begin
                        bit_d = bit_q + 4'd1;
                    end
                end
            end
`ifdef SCCB_DELAY_EN
            ST_DELAY: begin
                phase_d = 2'd0;
                if (ms_q == 23'd0) begin
                    bit_d   = 4'd0;
                    state_d = ST_GAP;
                end else begin
                    ms_d = ms_q - 23'd1;
                end
            end
`endif
            default: state_d = ST_IDLE;
        endcase
    end

    // State and counter registers; reset drops the bus immediately with no STOP.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            qcnt_q  <= '0;
            phase_q <= 2'd0;
            bit_q   <= 4'd0;
            byte_q  <= 2'd0;
            idx_q   <= 8'd0;
        end else begin
            state_q <= state_d;
            qcnt_q  <= qcnt_d;
            phase_q <= phase_d;
            bit_q   <= bit_d;
            byte_q  <= byte_d;
            idx_q   <= idx_d;
        end
    end

`ifdef SCCB_DELAY_EN
    // Millisecond pause counter.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) ms_q <= 23'd0;
        else          ms_q <= ms_d;
    end
`endif

endmodule

// File: tb/tb_sccb_config.sv
// Bench for sccb_config: five loaders with different tables share clk/reset.
// A bus decoder recovers SCCB writes from sioc/siod and compares them with
// the write list derived from each table.
module tb_sccb_config;

    localparam int NI   = 5;
    localparam int QTR  = 2;
    localparam int GAPB = 4;
    localparam int SEL  [NI] = '{1, 2, 3, 4, 2};
    localparam int NREG [NI] = '{64, 64, 64, 64, 1};
`ifdef SCCB_DELAY_EN
    localparam bit DLY = 1'b1;
`else
    localparam bit DLY = 1'b0;
`endif

    logic          clk     = 1'b0;
    logic          reset_n = 1'b0;
    logic [NI-1:0] start_w = '0;
    logic [NI-1:0] busy_w, done_w, sioc_w, siod_o_w, siod_oe_w;
    logic [7:0]    idx_w [NI];

    always #5 clk = ~clk;

    for (genvar gk = 0; gk < NI; gk++) begin : g_dut
        sccb_config #(
            .QTR_CYC   (QTR),
            .DEV_ID    (8'h42),
            .NUM_REGS  (NREG[gk]),
            .GAP_BITS  (GAPB),
            .TABLE_SEL (SEL[gk])
        ) u_dut (
            .clk     (clk),
            .reset_n (reset_n),
            .start   (start_w[gk]),
            .busy    (busy_w[gk]),
            .done    (done_w[gk]),
            .reg_idx (idx_w[gk]),
            .sioc    (sioc_w[gk]),
            .siod_o  (siod_o_w[gk]),
            .siod_oe (siod_oe_w[gk])
        );
    end

    // table contents as the bench knows them, and the expected write list
    logic [15:0] tab    [NI][4];
    logic [23:0] exp_tx [NI][4];
    int          exp_gap[NI][4];
    int          exp_n  [NI];
    int          exp_idx[NI];

    // bus decoder state per instance
    bit          prev_sioc [NI];
    bit          prev_line [NI];
    bit          prev_busy [NI];
    bit          prev_done [NI];
    bit          in_tx     [NI];
    int          nbits     [NI];
    int          rx_n      [NI];
    int          idle_cnt  [NI];
    int          stop_seen [NI];
    int          edges     [NI];
    logic [23:0] shreg     [NI];

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s[%0d] got %0h want %0h", nm, k, act, exp);
        end
    endtask

    task automatic chk_min(input string nm, input int k, input int act, input int min);
        checks++;
        if (act < min) begin
            errors++;
            $display("FAIL %s[%0d] got %0d want >= %0d", nm, k, act, min);
        end
    endtask

    // One sample of every bus; runs at each falling clk edge.
    task automatic mon_step();
        logic line;
        for (int k = 0; k < NI; k++) begin
            line = siod_oe_w[k] ? siod_o_w[k] : 1'b1;
            if (!reset_n) begin
                in_tx[k]     = 1'b0;
                prev_busy[k] = 1'b0;
                prev_done[k] = 1'b0;
            end else begin
                chk("busy_and_done", k, 32'(busy_w[k] & done_w[k]), 0);
                if (!busy_w[k]) chk("idle_bus", k, {30'd0, sioc_w[k], siod_oe_w[k]}, 32'h2);
                if (busy_w[k] && !prev_busy[k]) begin
                    rx_n[k]     = 0;
                    in_tx[k]    = 1'b0;
                    idle_cnt[k] = 0;
                end
                if (sioc_w[k] != prev_sioc[k]) edges[k]++;
                if (prev_sioc[k] && sioc_w[k] && prev_line[k] && !line) begin
                    chk("nested_start", k, 32'(in_tx[k]), 0);
                    if (rx_n[k] > 0 && rx_n[k] < 4) chk_min("gap_clk", k, idle_cnt[k], exp_gap[k][rx_n[k]]);
                    in_tx[k] = 1'b1;
                    nbits[k] = 0;
                    shreg[k] = '0;
                end else if (prev_sioc[k] && sioc_w[k] && !prev_line[k] && line) begin
                    stop_seen[k]++;
                    chk("stop_after_start", k, 32'(in_tx[k]), 1);
                    chk("bits_per_tx", k, nbits[k], 27);
                    if (rx_n[k] < exp_n[k]) chk("tx_bytes", k, 32'(shreg[k]), 32'(exp_tx[k][rx_n[k]]));
                    else                    chk("extra_tx", k, rx_n[k], exp_n[k]);
                    rx_n[k]++;
                    in_tx[k]    = 1'b0;
                    idle_cnt[k] = 0;
                end else if (!prev_sioc[k] && sioc_w[k] && in_tx[k] && nbits[k] < 27) begin
                    if (nbits[k] % 9 == 8) begin
                        chk("ack_released", k, 32'(siod_oe_w[k]), 0);
                    end else begin
                        chk("data_driven", k, 32'(siod_oe_w[k]), 1);
                        shreg[k] = {shreg[k][22:0], line};
                    end
                    nbits[k]++;
                end
                if (!in_tx[k]) idle_cnt[k]++;
                if (done_w[k] && !prev_done[k]) begin
                    chk("tx_count", k, rx_n[k], exp_n[k]);
                    chk("final_idx", k, 32'(idx_w[k]), exp_idx[k]);
                end
                prev_busy[k] = busy_w[k];
                prev_done[k] = done_w[k];
            end
            prev_sioc[k] = sioc_w[k];
            prev_line[k] = line;
        end
    endtask

    task automatic tick();
        @(negedge clk);
        mon_step();
    endtask

    task automatic pulse(input logic [NI-1:0] mask);
        start_w = mask;
        tick();
        start_w = '0;
    endtask

    initial begin
        int  idx, n, pend;
        bit  fin;
        bit  ok;

        tab[0] = '{16'h1280, 16'hFFFF, 16'hFFFF, 16'hFFFF};
        tab[1] = '{16'h3A04, 16'h40D0, 16'hFFFF, 16'hFFFF};
        tab[2] = '{16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF};
        tab[3] = '{16'h1280, 16'hF002, 16'h1101, 16'hFFFF};
        tab[4] = '{16'h3A04, 16'h40D0, 16'hFFFF, 16'hFFFF};
        for (int k = 0; k < NI; k++) begin
            prev_sioc[k] = 1'b1; prev_line[k] = 1'b1; in_tx[k] = 1'b0;
            prev_busy[k] = 1'b0; prev_done[k] = 1'b0;
            nbits[k] = 0; rx_n[k] = 0; idle_cnt[k] = 0; stop_seen[k] = 0; edges[k] = 0;
            shreg[k] = '0;
            idx = 0; n = 0; pend = 0; fin = 1'b0;
            while (!fin) begin
                if (idx == NREG[k] || tab[k][idx] == 16'hFFFF) begin
                    fin = 1'b1;
                end else begin
                    if (DLY && tab[k][idx][15:8] == 8'hF0) begin
                        pend += int'(tab[k][idx][7:0]) * 25000;
                    end else begin
                        exp_tx[k][n]  = {8'h42, tab[k][idx]};
                        exp_gap[k][n] = GAPB * 4 * QTR + pend;
                        pend = 0;
                        n++;
                    end
                    idx++;
                end
            end
            exp_n[k]   = n;
            exp_idx[k] = idx;
        end

        // model pinned against hand-worked values
        chk("model_t2_bytes", 0, 32'(exp_tx[0][0]), 32'h421280);
        chk("model_t2_n",     0, exp_n[0], 1);
        chk("model_t2_idx",   0, exp_idx[0], 1);
        chk("model_t3_bytes", 1, 32'(exp_tx[1][1]), 32'h4240D0);
        chk("model_t4_n",     2, exp_n[2], 0);
        chk("model_t6_bytes", 3, 32'(exp_tx[3][1]), DLY ? 32'h421101 : 32'h42F002);
        chk("model_t6_n",     3, exp_n[3], DLY ? 2 : 3);
        chk("model_stop_idx", 4, exp_idx[4], 1);

        // reset state
        repeat (3) tick();
        for (int k = 0; k < NI; k++) begin
            chk("rst_sioc",    k, 32'(sioc_w[k]), 1);
            chk("rst_siod_o",  k, 32'(siod_o_w[k]), 1);
            chk("rst_siod_oe", k, 32'(siod_oe_w[k]), 0);
            chk("rst_busy",    k, 32'(busy_w[k]), 0);
            chk("rst_done",    k, 32'(done_w[k]), 0);
            chk("rst_idx",     k, 32'(idx_w[k]), 0);
        end
        reset_n = 1'b1;
        repeat (2) tick();

        // T1: abort mid-byte with reset
        pulse(5'b00001);
        chk("busy_after_start", 0, 32'(busy_w[0]), 1);
        ok = 1'b0;
        for (int i = 0; i < 500 && !ok; i++) begin
            tick();
            ok = in_tx[0] && nbits[0] >= 3 && !sioc_w[0];
        end
        chk("t1_reach_byte", 0, 32'(ok), 1);
        #1 reset_n = 1'b0;
        #1;
        chk("t1_sioc",    0, 32'(sioc_w[0]), 1);
        chk("t1_siod_oe", 0, 32'(siod_oe_w[0]), 0);
        chk("t1_busy",    0, 32'(busy_w[0]), 0);
        chk("t1_done",    0, 32'(done_w[0]), 0);
        repeat (2) tick();
        reset_n = 1'b1;
        repeat (3) tick();
        chk("t1_no_stop", 0, stop_seen[0], 0);

        // T2..T6: start every loader together
        pulse(5'b11111);
        for (int k = 0; k < NI; k++) chk("busy_after_start", k, 32'(busy_w[k]), 1);
        for (int i = 0; i < 3 && !done_w[2]; i++) tick();
        chk("t4_done_latency", 2, 32'(done_w[2]), 1);

        // T5: starts while busy must be ignored
        repeat (50) tick();
        pulse(5'b00010);
        repeat (200) tick();
        pulse(5'b00010);

        ok = 1'b0;
        for (int i = 0; i < 60000 && !ok; i++) begin
            tick();
            ok = &done_w;
        end
        chk("all_done", 0, 32'(ok), 1);
        for (int k = 0; k < NI; k++) begin
            chk("done_held", k, 32'(done_w[k]), 1);
            chk("busy_low",  k, 32'(busy_w[k]), 0);
        end
        chk("t4_no_sioc_edge", 2, edges[2], 0);
        chk("t3_stops",        1, stop_seen[1], 2);

        // T5: a start after done repeats the sequence
        pulse(5'b00010);
        chk("t5_done_drops", 1, 32'(done_w[1]), 0);
        chk("t5_busy",       1, 32'(busy_w[1]), 1);
        chk("t5_idx_restart", 1, 32'(idx_w[1]), 0);
        ok = 1'b0;
        for (int i = 0; i < 2000 && !ok; i++) begin
            tick();
            ok = done_w[1];
        end
        chk("t5_redone", 1, 32'(ok), 1);
        chk("t5_stops",  1, stop_seen[1], 4);
        chk("t5_idx",    1, 32'(idx_w[1]), 2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
